vdg_raster_gen: RTL and testbench
=================================

# vdg_raster_gen

Parametrised raster timing and display-address generator for the 6847 replacement, superseding the fixed-geometry timing in the current VDG core. It produces the VDG-compatible sync strobes (HSn, FSn, RPn), the display-memory address with DA0, and active/border qualifiers for the pixel pipeline. Geometry is set by parameters. Lines-per-character-row is selectable at run time, and NTSC/PAL frame length is selected per frame. It sits between the clock/enable logic and the character/graphics pixel serialiser.

## Interface
Parameters:
- H_SYNC, 20, horizontal sync width (pixel enables)
- H_BACK, 21, back porch
- H_LBORDER, 28, left border
- H_ACTIVE, 256, active pixels per line (multiple of BYTE_PIXELS)
- H_RBORDER, 28, right border
- H_FRONT, 7, front porch (H_TOTAL = sum = 360)
- V_SYNC, 3; V_BACK, 13; V_TOP, 25; V_ACTIVE, 192; V_BOTTOM, 26; V_FRONT, 3 (NTSC V_TOTAL = 262)
- PAL_PAD, 25, extra border lines added to both top and bottom in PAL (V_TOTAL = 312)
- BYTE_PIXELS, 8, pixels per display byte
- ADDR_W, 13, address width

Ports:
- GClk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- PixEn  in  1  pixel-clock enable; all counters advance only when high
- Format  in  1  1 = NTSC, 0 = PAL; latched at frame start
- LinesPerRow  in  4  scan lines per address row; latched at frame start; 0 treated as 1
- HSn  out  1  horizontal sync, active low
- FSn  out  1  field sync, active low
- RPn  out  1  row preset, active low
- Active  out  1  in active pixel area
- Border  out  1  in border area (visible, not active)
- Addr  out  ADDR_W  display byte address
- DA0  out  1  equals Addr[0]
- FrameStart  out  1  one-enable pulse on the first pixel of each frame

## Operation
- hcount runs 0..H_TOTAL-1. Regions in order: sync, back porch, left border, active, right border, front porch.
- vcount runs 0..V_TOTAL-1. Regions in order: sync, back, top border, active, bottom border, front.
- In PAL, top and bottom borders are each extended by PAL_PAD.
- vcount advances when hcount wraps.
- HSn = 0 while hcount < H_SYNC.
- FSn = 0 while vcount < V_SYNC.
- RPn = 0 while HSn = 0 on the last top-border line.
- Border = visible region (line not in sync/porch, pixel not in sync/porch) and not Active.
- Frame start (hcount=0, vcount=0):
  - latch Format and LinesPerRow;
  - rowbase ← 0, rowline ← 0, Addr ← 0.
- First active pixel of each active line: Addr ← rowbase.
- Addr increments after every BYTE_PIXELS active pixels. It holds outside the active area.
- Last active pixel of a line:
  - if rowline = LPR−1: rowbase ← rowbase + H_ACTIVE/BYTE_PIXELS, rowline ← 0;
  - else rowline ← rowline + 1. The next line then repeats the same bytes.
- All address arithmetic wraps modulo 2^ADDR_W.
- Format or LinesPerRow changes mid-frame have no effect until the next frame start.

## Timing
- All outputs are registered.
- Each output takes its new value on the same GClk edge (with PixEn = 1) on which the counters enter the corresponding position. There is zero enable latency between the counter position and the output.
- PixEn = 0: counters, latches and all outputs hold. FrameStart is held too, so it stays high across stalls and is qualified by PixEn downstream.
- Reset values:
  - hcount = H_TOTAL−1, vcount = V_TOTAL−1 of NTSC;
  - HSn = FSn = RPn = 1;
  - Active = Border = FrameStart = 0;
  - Addr = 0, DA0 = 0;
  - latched Format = NTSC, latched LPR = 1.
- The first PixEn after reset release enters (0,0): HSn = 0, FSn = 0, FrameStart = 1.
- Reset asserted mid-frame forces the reset values immediately, regardless of PixEn.

## Configuration
- VDG_PAL_FORMAT_EN defined: Format is honoured, so PAL frames are 312 lines with padded borders.
- VDG_PAL_FORMAT_EN undefined:
  - Format is ignored and the block is permanently NTSC (262 lines);
  - PAL_PAD logic is removed.

## Test plan
- Reset during active line 50, then release → outputs immediately at reset values. The first PixEn gives HSn = 0, FSn = 0, FrameStart = 1.
- Default parameters, PixEn always high → HSn low exactly 20 cycles out of every 360. Active high 256 cycles per active line, starting at hcount 69.
- Format = 1 → FSn low for 3 lines, FrameStart period 94320 enables. Active asserted on exactly 192 lines.
- LinesPerRow = 12 → Addr = 0 at the start of active lines 0..11 and 32 at line 12; the final Addr of the frame is 511. With LinesPerRow = 0 → treated as 1, and the final Addr is 6143.
- VDG_PAL_FORMAT_EN defined, Format driven 1→0 mid-frame → the current frame stays 262 lines, the next frame is 312 lines with the first active line at vcount 66. With the macro undefined, both frames are 262 lines.
- PixEn toggled 1-in-3 → all outputs are the same enable-for-enable sequence as with PixEn always high, and hold between enables.

Source files
------------

// File: rtl/vdg_raster_gen_if.sv
// Pixel-pipeline bundle for vdg_raster_gen: enable/format controls in,
// VDG sync strobes, qualifiers and display address out.
interface vdg_raster_gen_if #(
    parameter int ADDR_W = 13
);
    logic              PixEn;
    logic              Format;
    logic [3:0]        LinesPerRow;
    logic              HSn;
    logic              FSn;
    logic              RPn;
    logic              Active;
    logic              Border;
    logic [ADDR_W-1:0] Addr;
    logic              DA0;
    logic              FrameStart;

    modport master (
        output PixEn, Format, LinesPerRow,
        input  HSn, FSn, RPn, Active, Border, Addr, DA0, FrameStart
    );

    modport slave (
        input  PixEn, Format, LinesPerRow,
        output HSn, FSn, RPn, Active, Border, Addr, DA0, FrameStart
    );
endinterface

// File: rtl/vdg_raster_gen.sv
// Parametrised 6847-compatible raster timing and display-address generator.
// Define VDG_PAL_FORMAT_EN to honour Format (PAL, 312 lines); else NTSC only.
module vdg_raster_gen #(
    parameter int H_SYNC      = 20,
    parameter int H_BACK      = 21,
    parameter int H_LBORDER   = 28,
    parameter int H_ACTIVE    = 256,
    parameter int H_RBORDER   = 28,
    parameter int H_FRONT     = 7,
    parameter int V_SYNC      = 3,
    parameter int V_BACK      = 13,
    parameter int V_TOP       = 25,
    parameter int V_ACTIVE    = 192,
    parameter int V_BOTTOM    = 26,
    parameter int V_FRONT     = 3,
    parameter int PAL_PAD     = 25,
    parameter int BYTE_PIXELS = 8,
    parameter int ADDR_W      = 13
) (
    input  logic            GClk,
    input  logic            Reset,
    vdg_raster_gen_if.slave bus
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_LBORDER + H_ACTIVE
                           + H_RBORDER + H_FRONT;
    localparam int V_NTSC  = V_SYNC + V_BACK + V_TOP + V_ACTIVE
                           + V_BOTTOM + V_FRONT;
    localparam int V_MAX   = V_NTSC + 2 * PAL_PAD;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_MAX);
    localparam int BW      = (BYTE_PIXELS > 1) ? $clog2(BYTE_PIXELS) : 1;

    typedef logic [HW-1:0]     h_t;
    typedef logic [VW-1:0]     v_t;
    typedef logic [BW-1:0]     b_t;
    typedef logic [ADDR_W-1:0] a_t;

    localparam h_t H_LAST    = h_t'(H_TOTAL - 1);
    localparam h_t H_SY      = h_t'(H_SYNC);
    localparam h_t H_VIS_LO  = h_t'(H_SYNC + H_BACK);
    localparam h_t H_ACT_LO  = h_t'(H_SYNC + H_BACK + H_LBORDER);
    localparam h_t H_ACT_HI  = h_t'(H_SYNC + H_BACK + H_LBORDER + H_ACTIVE);
    localparam h_t H_ACT_END = h_t'(H_SYNC + H_BACK + H_LBORDER + H_ACTIVE - 1);
    localparam h_t H_VIS_HI  = h_t'(H_TOTAL - H_FRONT);

    localparam v_t V_LAST_N  = v_t'(V_NTSC - 1);
    localparam v_t V_SY      = v_t'(V_SYNC);
    localparam v_t V_VIS_LO  = v_t'(V_SYNC + V_BACK);
    localparam v_t V_ACT_LO  = v_t'(V_SYNC + V_BACK + V_TOP);
    localparam v_t V_ACT_HI  = v_t'(V_SYNC + V_BACK + V_TOP + V_ACTIVE);
    localparam v_t V_VIS_HI  = v_t'(V_NTSC - V_FRONT);

    localparam b_t BP_LAST   = b_t'(BYTE_PIXELS - 1);
    localparam a_t ROW_STEP  = a_t'(H_ACTIVE / BYTE_PIXELS);

    // Raster position and its value after the next enabled edge
    h_t hcnt_q, hcnt_d;
    v_t vcnt_q, vcnt_d;
    logic h_wrap;

    // Address generation state
    a_t         addr_q, addr_d;
    a_t         rowbase_q, rowbase_d;
    logic [3:0] rowline_q, rowline_d;
    b_t         bcnt_q, bcnt_d;
    logic [3:0] lpr_q, lpr_d;

    // Registered outputs
    logic hsn_q, hsn_d;
    logic fsn_q, fsn_d;
    logic rpn_q, rpn_d;
    logic act_q, act_d;
    logic brd_q, brd_d;
    logic fs_q, fs_d;

    // Border padding of the frame being entered, and length padding of
    // the frame in progress (the wrap point must use the old format).
    v_t pad_next;
    v_t pad2_cur;

    v_t   v_act_lo, v_act_hi, v_vis_hi;
    logic v_act, v_vis, h_act, h_vis;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + h_t'(1);
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            if (vcnt_q == V_LAST_N + pad2_cur) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + v_t'(1);
            end
        end
    end

    assign fs_d = (hcnt_d == '0) && (vcnt_d == '0);

`ifdef VDG_PAL_FORMAT_EN
    localparam v_t PAD  = v_t'(PAL_PAD);
    localparam v_t PAD2 = v_t'(2 * PAL_PAD);

    logic fmt_q, fmt_d;

    assign fmt_d    = fs_d ? bus.Format : fmt_q;
    assign pad_next = fmt_d ? '0 : PAD;
    assign pad2_cur = fmt_q ? '0 : PAD2;

    always_ff @(posedge GClk or posedge Reset) begin
        if (Reset) begin
            fmt_q <= 1'b1;
        end else if (bus.PixEn) begin
            fmt_q <= fmt_d;
        end
    end
`else
    logic unused_format;

    assign unused_format = bus.Format;
    assign pad_next      = '0;
    assign pad2_cur      = '0;
`endif

    assign lpr_d = !fs_d ? lpr_q
                 : (bus.LinesPerRow == 4'd0) ? 4'd1
                 : bus.LinesPerRow;

    // Region decode of the position being entered
    assign v_act_lo = V_ACT_LO + pad_next;
    assign v_act_hi = V_ACT_HI + pad_next;
    assign v_vis_hi = V_VIS_HI + pad_next + pad_next;

    assign v_act = (vcnt_d >= v_act_lo) && (vcnt_d < v_act_hi);
    assign v_vis = (vcnt_d >= V_VIS_LO) && (vcnt_d < v_vis_hi);
    assign h_act = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI);
    assign h_vis = (hcnt_d >= H_VIS_LO) && (hcnt_d < H_VIS_HI);

    assign act_d = v_act && h_act;
    assign brd_d = v_vis && h_vis && !act_d;
    assign hsn_d = (hcnt_d >= H_SY);
    assign fsn_d = (vcnt_d >= V_SY);
    assign rpn_d = hsn_d || (vcnt_d != v_act_lo - v_t'(1));

    always_comb begin
        addr_d    = addr_q;
        bcnt_d    = bcnt_q;
        rowbase_d = rowbase_q;
        rowline_d = rowline_q;
        if (fs_d) begin
            addr_d    = '0;
            bcnt_d    = '0;
            rowbase_d = '0;
            rowline_d = '0;
        end else if (act_d) begin
            if (hcnt_d == H_ACT_LO) begin
                addr_d = rowbase_q;
                bcnt_d = '0;
            end else if (bcnt_q == BP_LAST) begin
                addr_d = addr_q + a_t'(1);
                bcnt_d = '0;
            end else begin
                bcnt_d = bcnt_q + b_t'(1);
            end
            // Row advance decided on the last active pixel of the line
            if (hcnt_d == H_ACT_END) begin
                if (rowline_q == lpr_q - 4'd1) begin
                    rowbase_d = rowbase_q + ROW_STEP;
                    rowline_d = '0;
                end else begin
                    rowline_d = rowline_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge GClk or posedge Reset) begin
        if (Reset) begin
            hcnt_q    <= H_LAST;
            vcnt_q    <= V_LAST_N;
            lpr_q     <= 4'd1;
            addr_q    <= '0;
            rowbase_q <= '0;
            rowline_q <= '0;
            bcnt_q    <= '0;
            hsn_q     <= 1'b1;
            fsn_q     <= 1'b1;
            rpn_q     <= 1'b1;
            act_q     <= 1'b0;
            brd_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else if (bus.PixEn) begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            lpr_q     <= lpr_d;
            addr_q    <= addr_d;
            rowbase_q <= rowbase_d;
            rowline_q <= rowline_d;
            bcnt_q    <= bcnt_d;
            hsn_q     <= hsn_d;
            fsn_q     <= fsn_d;
            rpn_q     <= rpn_d;
            act_q     <= act_d;
            brd_q     <= brd_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.HSn        = hsn_q;
    assign bus.FSn        = fsn_q;
    assign bus.RPn        = rpn_q;
    assign bus.Active     = act_q;
    assign bus.Border     = brd_q;
    assign bus.Addr       = addr_q;
    assign bus.DA0        = addr_q[0];
    assign bus.FrameStart = fs_q;

endmodule

// File: tb/tb_vdg_raster_gen.sv
// Scoreboard bench for vdg_raster_gen on a reduced geometry (50 x 37/45).
// Per-frame statistics are compared against queued hand-derived values.
`timescale 1ns/1ps
module tb_vdg_raster_gen;

    localparam int HS = 4, HB = 3, HL = 5, HA = 32, HR = 4, HF = 2;
    localparam int HT = HS + HB + HL + HA + HR + HF;
    localparam int VS = 3, VB = 2, VTP = 3, VA = 24, VBT = 3, VF = 2;
    localparam int PAD = 4, BP = 8, AW = 6;

`ifdef VDG_PAL_FORMAT_EN
    localparam bit PAL_OK = 1'b1;
`else
    localparam bit PAL_OK = 1'b0;
`endif

    typedef struct {
        int len;
        int hs_en;
        int fs_en;
        int act_en;
        int act_lines;
        int border;
        int first_act;
        int rp_idx;
        int rp_en;
        int last_addr;
        int addr_sum;
        int da0_bad;
        int fs_cyc;
        int hs_run;
    } fstat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vdg_raster_gen_if #(.ADDR_W(AW)) bus ();

    vdg_raster_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_LBORDER(HL), .H_ACTIVE(HA),
        .H_RBORDER(HR), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VTP), .V_ACTIVE(VA),
        .V_BOTTOM(VBT), .V_FRONT(VF),
        .PAL_PAD(PAD), .BYTE_PIXELS(BP), .ADDR_W(AW)
    ) dut (
        .GClk(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected statistics of one complete frame
    function automatic fstat_t make_exp(bit pal, int lpr, int dv);
        fstat_t e;
        int vt, top, l, base;
        vt  = VS + VB + VTP + VA + VBT + VF + (pal ? 2 * PAD : 0);
        top = VTP + (pal ? PAD : 0);
        l   = (lpr == 0) ? 1 : lpr;
        e.len       = HT * vt;
        e.hs_en     = HS * vt;
        e.fs_en     = VS * HT;
        e.act_en    = HA * VA;
        e.act_lines = VA;
        e.border    = (HL + HA + HR) * (top + VA + VBT + (pal ? PAD : 0))
                    - HA * VA;
        e.first_act = (VS + VB + top) * HT + HS + HB + HL;
        e.rp_idx    = (VS + VB + top - 1) * HT;
        e.rp_en     = HS;
        e.last_addr = 0;
        e.addr_sum  = 0;
        for (int k = 0; k < VA; k++) begin
            base = (k / l) * (HA / BP);
            for (int p = 0; p < HA; p++) begin
                e.last_addr = (base + p / BP) % (1 << AW);
                e.addr_sum += e.last_addr;
            end
        end
        e.da0_bad = 0;
        e.fs_cyc  = dv;
        e.hs_run  = HS * dv;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    fstat_t expq[$];
    fstat_t cur;
    int     idx;
    int     frames_seen = 0;
    int     frames_cmp  = 0;
    bit     have_prev   = 1'b0;
    bit     prev_act;
    bit     mon_en;

    task automatic compare_frame(input fstat_t a);
        fstat_t e;
        string  p;
        frames_cmp++;
        p = $sformatf("frame%0d", frames_cmp);
        if (expq.size() == 0) begin
            chk({p, "_expectation"}, 0, 1);
        end else begin
            e = expq.pop_front();
            chk({p, "_len"},       a.len,       e.len);
            chk({p, "_hs_en"},     a.hs_en,     e.hs_en);
            chk({p, "_fs_en"},     a.fs_en,     e.fs_en);
            chk({p, "_act_en"},    a.act_en,    e.act_en);
            chk({p, "_act_lines"}, a.act_lines, e.act_lines);
            chk({p, "_border"},    a.border,    e.border);
            chk({p, "_first_act"}, a.first_act, e.first_act);
            chk({p, "_rp_idx"},    a.rp_idx,    e.rp_idx);
            chk({p, "_rp_en"},     a.rp_en,     e.rp_en);
            chk({p, "_last_addr"}, a.last_addr, e.last_addr);
            chk({p, "_addr_sum"},  a.addr_sum,  e.addr_sum);
            chk({p, "_da0_bad"},   a.da0_bad,   e.da0_bad);
            chk({p, "_fs_cyc"},    a.fs_cyc,    e.fs_cyc);
            chk({p, "_hs_run"},    a.hs_run,    e.hs_run);
        end
    endtask

    always @(posedge clk) begin
        mon_en = bus.PixEn;
        #1;
        if (rst) begin
            have_prev   = 1'b0;
            frames_seen = 0;
        end else begin
            if (mon_en && bus.FrameStart) begin
                if (have_prev) begin
                    cur.len = idx;
                    compare_frame(cur);
                end
                cur = '{default: 0};
                cur.first_act = -1;
                cur.rp_idx    = -1;
                idx       = 0;
                prev_act  = 1'b0;
                have_prev = 1'b1;
                frames_seen++;
            end
            if (have_prev) begin
                if (bus.FrameStart) cur.fs_cyc++;
                if (!bus.HSn && idx < HT) cur.hs_run++;
                if (mon_en) begin
                    if (!bus.HSn) cur.hs_en++;
                    if (!bus.FSn) cur.fs_en++;
                    if (bus.Border) cur.border++;
                    if (!bus.RPn) begin
                        cur.rp_en++;
                        if (cur.rp_idx < 0) cur.rp_idx = idx;
                    end
                    if (bus.Active) begin
                        cur.act_en++;
                        if (!prev_act) cur.act_lines++;
                        if (cur.first_act < 0) cur.first_act = idx;
                        cur.last_addr = int'(bus.Addr);
                        cur.addr_sum += int'(bus.Addr);
                    end
                    if (bus.DA0 != bus.Addr[0]) cur.da0_bad++;
                    prev_act = bus.Active;
                    idx++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int mode  = 0;
    int phase = 0;

    task automatic cyc();
        @(negedge clk);
        if (mode == 3) begin
            bus.PixEn = (phase == 0);
            phase = (phase + 1) % 3;
        end else begin
            bus.PixEn = (mode != 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_frames(input int target, input string nm);
        int b;
        b = 20000;
        while (frames_seen < target && b > 0) begin
            cyc();
            b--;
        end
        chk(nm, int'(frames_seen >= target), 1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_HSn"},        int'(bus.HSn),        1);
        chk({p, "_FSn"},        int'(bus.FSn),        1);
        chk({p, "_RPn"},        int'(bus.RPn),        1);
        chk({p, "_Active"},     int'(bus.Active),     0);
        chk({p, "_Border"},     int'(bus.Border),     0);
        chk({p, "_FrameStart"}, int'(bus.FrameStart), 0);
        chk({p, "_Addr"},       int'(bus.Addr),       0);
        chk({p, "_DA0"},        int'(bus.DA0),        0);
    endtask

    initial begin
        bus.PixEn       = 1'b0;
        bus.Format      = 1'b1;
        bus.LinesPerRow = 4'd1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("release_hold");

        // Run into active line 12 (active row 4), pixel 20
        mode = 1;
        run(621);
        @(posedge clk);
        #1;
        chk("midline_Active", int'(bus.Active), 1);
        chk("midline_Addr", int'(bus.Addr), 17);
        #2 rst = 1'b1;
        #1 chk_reset("async_reset");
        @(negedge clk);
        mode = 0;
        bus.PixEn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("release2");

        expq.push_back(make_exp(1'b0, 1, 1));
        expq.push_back(make_exp(1'b0, 12, 1));
        expq.push_back(make_exp(1'b0, 0, 1));
        expq.push_back(make_exp(PAL_OK, 5, 1));
        expq.push_back(make_exp(1'b0, 3, 3));

        mode = 1;
        cyc();
        @(posedge clk);
        #2;
        chk("first_en_HSn", int'(bus.HSn), 0);
        chk("first_en_FSn", int'(bus.FSn), 0);
        chk("first_en_FrameStart", int'(bus.FrameStart), 1);
        chk("first_en_Active", int'(bus.Active), 0);

        run(700);
        bus.LinesPerRow = 4'd12;
        wait_frames(2, "frame2_start");
        run(700);
        bus.LinesPerRow = 4'd0;
        wait_frames(3, "frame3_start");
        run(700);
        bus.Format      = 1'b0;
        bus.LinesPerRow = 4'd5;
        wait_frames(4, "frame4_start");
        run(700);
        bus.Format      = 1'b1;
        bus.LinesPerRow = 4'd3;
        phase = 0;
        mode  = 3;
        wait_frames(6, "frame6_start");
        repeat (2) @(negedge clk);

        chk("frames_compared", frames_cmp, 5);
        chk("queue_left", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
